// File: rtl/pwm_audio_out.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_audio_out
//  Purpose  : Converts the sound generator's N-bit sample into a single-bit
//             PWM stream, with a per-period gain envelope for click-free
//             fade-in/fade-out and a coarse power-of-two volume attenuation.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_audio_out #(
   parameter int N = 7
) (
   input  logic         clk,
   input  logic         nRst,
   input  logic [N-1:0] sample_i,
   input  logic         enable_i,
   input  logic [1:0]   volume_i,
   output logic         pwm_o,
   output logic         period_start_o,
   output logic         active_o
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      PLAY      = 2'd2,
      RAMP_DOWN = 2'd3
   } state_t;

   localparam logic [N-1:0] c_cnt_max   = {N{1'b1}};
   localparam logic [3:0]   c_gain_full = 4'd8;
   localparam logic [3:0]   c_gain_top  = 4'd7;   // last gain before full
   localparam logic [3:0]   c_gain_one  = 4'd1;   // last gain before silence

   state_t       r_state;
   state_t       w_state_next;
   logic [N-1:0] r_cnt;
   logic [N-1:0] r_duty;
   logic [N-1:0] w_duty_next;
   logic [3:0]   r_gain;
   logic [3:0]   w_gain_next;
   logic         r_period_start;
   logic         w_boundary;
   logic [N+3:0] w_product;

   // The last count of a period is the only point where envelope and duty move.
   assign w_boundary = (r_cnt == c_cnt_max);

   // Free-running period counter; wraps naturally at 2^N.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + {{(N-1){1'b0}}, 1'b1};
      end
   end

   // Envelope next-state and next-gain; gain saturates at 0 and 8 by construction.
   always_comb begin
      w_state_next = r_state;
      w_gain_next  = r_gain;
      case (r_state)
         IDLE: begin
            if (enable_i) begin
               w_state_next = RAMP_UP;
               w_gain_next  = c_gain_one;
            end else begin
               w_gain_next  = 4'd0;
            end
         end
         RAMP_UP: begin
            if (!enable_i) begin
               w_gain_next  = r_gain - 4'd1;
               w_state_next = (r_gain == c_gain_one) ? IDLE : RAMP_DOWN;
            end else begin
               w_gain_next  = r_gain + 4'd1;
               w_state_next = (r_gain == c_gain_top) ? PLAY : RAMP_UP;
            end
         end
         PLAY: begin
            if (!enable_i) begin
               w_state_next = RAMP_DOWN;
               w_gain_next  = c_gain_top;
            end else begin
               w_gain_next  = c_gain_full;
            end
         end
         RAMP_DOWN: begin
            if (enable_i) begin
               w_gain_next  = r_gain + 4'd1;
               w_state_next = (r_gain == c_gain_top) ? PLAY : RAMP_UP;
            end else begin
               w_gain_next  = r_gain - 4'd1;
               w_state_next = (r_gain == c_gain_one) ? IDLE : RAMP_DOWN;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_gain_next  = 4'd0;
         end
      endcase
   end

   // Gain of 8 is unity after the /8, so the scaled duty never exceeds 2^N-1.
   assign w_product   = {4'b0000, sample_i} * {{N{1'b0}}, w_gain_next};
   assign w_duty_next = N'(w_product >> (3'd3 + {1'b0, volume_i}));

   // Envelope state, gain and duty are latched only at the period boundary.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state <= IDLE;
         r_gain  <= '0;
         r_duty  <= '0;
      end else if (w_boundary) begin
         r_state <= w_state_next;
         r_gain  <= w_gain_next;
         r_duty  <= w_duty_next;
      end
   end

   // Registered boundary flag: high exactly while the counter sits at zero.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= w_boundary;
      end
   end

   assign pwm_o          = (r_cnt < r_duty);
   assign period_start_o = r_period_start;
   assign active_o       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pwm_audio_out.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_audio_out
//  Purpose  : Self-checking bench for pwm_audio_out (N=7). Expected duty per
//             period is queued at each boundary and compared while the
//             following period plays out.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_audio_out;

   logic       clk = 1'b0;
   logic       nRst;
   logic [6:0] sample;
   logic       enable;
   logic [1:0] volume;
   logic       pwm;
   logic       period_start;
   logic       active;

   int checks   = 0;
   int failures = 0;
   int exp_q[$];
   int m_gain;
   bit first_period;

   pwm_audio_out #(.N(7)) dut (
      .clk            (clk),
      .nRst           (nRst),
      .sample_i       (sample),
      .enable_i       (enable),
      .volume_i       (volume),
      .pwm_o          (pwm),
      .period_start_o (period_start),
      .active_o       (active)
   );

   always #5 clk = ~clk;

   // Runs one 128-cycle period starting at cnt==0 (sampled on negedges).
   task automatic run_period(input logic en, input logic [6:0] smp, input logic [1:0] vol,
                             input int chg_at, input logic [6:0] smp2, output int highs);
      int exp_duty;
      int bad;
      int ps_bad;
      int exp_act;
      enable = en;
      sample = smp;
      volume = vol;
      highs  = 0;
      bad    = 0;
      ps_bad = 0;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty: got 0 entries expected >=1");
         exp_duty = 0;
      end else begin
         exp_duty = exp_q.pop_front();
      end
      exp_act = (m_gain != 0) ? 1 : 0;
      checks++;
      if (active !== exp_act[0]) begin
         failures++;
         $display("FAIL active: got %b expected %0d", active, exp_act);
      end
      for (int i = 0; i < 128; i++) begin
         if (i == chg_at) sample = smp2;
         if (pwm === 1'b1) highs++;
         if (pwm !== (i < exp_duty)) bad++;
         if (period_start !== ((i == 0) && !first_period)) ps_bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL pwm_shape: got %0d bad samples (highs=%0d) expected 0 (duty=%0d)",
                  bad, highs, exp_duty);
      end
      checks++;
      if (ps_bad != 0) begin
         failures++;
         $display("FAIL period_start: got %0d bad samples expected 0", ps_bad);
      end
      // Reference envelope: step toward 8 when enabled, toward 0 otherwise.
      if (enable) m_gain = (m_gain >= 8) ? 8 : m_gain + 1;
      else        m_gain = (m_gain <= 0) ? 0 : m_gain - 1;
      exp_q.push_back((int'(sample) * m_gain) / 8 / (1 << volume));
      first_period = 1'b0;
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_q.push_back(0);
      m_gain       = 0;
      first_period = 1'b1;
   endtask

   task automatic test_reset();
      nRst   = 1'b0;
      enable = 1'b1;
      sample = 7'd100;
      volume = 2'd0;
      repeat (3) @(negedge clk);
      checks++;
      if ({pwm, active, period_start} !== 3'b000) begin
         failures++;
         $display("FAIL reset_outputs: got %b expected 000", {pwm, active, period_start});
      end
      model_reset();
      nRst = 1'b1;
   endtask

   task automatic test_fade_in();
      int tbl[8] = '{12, 25, 37, 50, 62, 75, 87, 100};
      int h;
      for (int k = 0; k < 9; k++) begin
         run_period(1'b1, 7'd100, 2'd0, -1, 7'd0, h);
         if (k > 0) begin
            checks++;
            if (h != tbl[k-1]) begin
               failures++;
               $display("FAIL fade_in_p%0d: got %0d expected %0d", k + 1, h, tbl[k-1]);
            end
         end
      end
      run_period(1'b1, 7'd100, 2'd0, -1, 7'd0, h);
      checks++;
      if (h != 100 || active !== 1'b1) begin
         failures++;
         $display("FAIL play_duty: got highs=%0d active=%b expected 100 1", h, active);
      end
   endtask

   task automatic test_volume();
      int vt[4] = '{127, 63, 31, 15};
      int h;
      run_period(1'b1, 7'd127, 2'd0, -1, 7'd0, h);
      for (int v = 1; v < 4; v++) begin
         run_period(1'b1, 7'd127, v[1:0], -1, 7'd0, h);
         checks++;
         if (h != vt[v-1]) begin
            failures++;
            $display("FAIL volume_%0d: got %0d expected %0d", v - 1, h, vt[v-1]);
         end
      end
      run_period(1'b1, 7'd100, 2'd0, -1, 7'd0, h);
      checks++;
      if (h != vt[3]) begin
         failures++;
         $display("FAIL volume_3: got %0d expected %0d", h, vt[3]);
      end
   endtask

   task automatic test_fade_out_reversal();
      int fo[14] = '{87, 75, 62, 75, 87, 100, 87, 75, 62, 50, 37, 25, 12, 0};
      int h;
      for (int j = 0; j < 15; j++) begin
         run_period((j >= 3 && j <= 5), 7'd100, 2'd0, -1, 7'd0, h);
         if (j > 0) begin
            checks++;
            if (h != fo[j-1]) begin
               failures++;
               $display("FAIL fade_out_step%0d: got %0d expected %0d", j, h, fo[j-1]);
            end
         end
      end
      checks++;
      if (active !== 1'b0) begin
         failures++;
         $display("FAIL fade_out_active: got %b expected 0", active);
      end
      run_period(1'b0, 7'd100, 2'd0, -1, 7'd0, h);
      checks++;
      if (h != 0) begin
         failures++;
         $display("FAIL idle_silent: got %0d expected 0", h);
      end
   endtask

   task automatic test_mid_period_sample();
      int h;
      for (int k = 0; k < 8; k++) run_period(1'b1, 7'd100, 2'd0, -1, 7'd0, h);
      run_period(1'b1, 7'd100, 2'd0, 50, 7'd20, h);
      checks++;
      if (h != 100) begin
         failures++;
         $display("FAIL mid_change_current: got %0d expected 100", h);
      end
      run_period(1'b1, 7'd20, 2'd0, -1, 7'd0, h);
      checks++;
      if (h != 20) begin
         failures++;
         $display("FAIL mid_change_next: got %0d expected 20", h);
      end
   endtask

   task automatic test_extremes();
      int h;
      run_period(1'b1, 7'd0, 2'd0, -1, 7'd0, h);
      run_period(1'b1, 7'd0, 2'd0, -1, 7'd0, h);
      checks++;
      if (h != 0) begin
         failures++;
         $display("FAIL sample_zero: got %0d expected 0", h);
      end
      run_period(1'b1, 7'd127, 2'd0, -1, 7'd0, h);
      run_period(1'b1, 7'd127, 2'd0, -1, 7'd0, h);
      checks++;
      if (h != 127) begin
         failures++;
         $display("FAIL sample_max: got %0d expected 127", h);
      end
   endtask

   task automatic test_async_reset();
      int h;
      // Entering at cnt==0 in PLAY with duty 127: pwm and period_start are high.
      #2;
      nRst = 1'b0;
      #1;
      checks++;
      if ({pwm, active, period_start} !== 3'b000) begin
         failures++;
         $display("FAIL async_reset: got %b expected 000", {pwm, active, period_start});
      end
      @(negedge clk);
      @(negedge clk);
      model_reset();
      nRst = 1'b1;
      run_period(1'b1, 7'd100, 2'd0, -1, 7'd0, h);
      checks++;
      if (h != 0) begin
         failures++;
         $display("FAIL restart_p1: got %0d expected 0", h);
      end
      run_period(1'b1, 7'd100, 2'd0, -1, 7'd0, h);
      checks++;
      if (h != 12) begin
         failures++;
         $display("FAIL restart_p2: got %0d expected 12", h);
      end
   endtask

   initial begin
      test_reset();
      test_fade_in();
      test_volume();
      test_fade_out_reversal();
      test_mid_period_sample();
      test_extremes();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
